round_timer: RTL and testbench

ROUND_TIMER -- requirements
Module: round_timer

---
 rtl/round_timer.sv | 146 ++++++++++++++
 tb/tb_round_timer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/round_timer.sv
// round_timer -- countdown timer for a game round, in whole seconds.
//
// One Ten pulse counts down one second while running. The round length
// can be reloaded (it saturates at 99). Start begins, resumes or
// restarts a round. Pause holds the count. Only one event acts per
// cycle, in this priority order: Reset, Load, Start, Pause, Ten.
//
// Parameters:
//   DEFAULT_SECONDS  Round length loaded at reset (1..99).
//
// Ports:
//   Clock      in   System clock. Everything changes on the rising edge.
//   Reset      in   Synchronous reset, active low.
//   Ten        in   Single-cycle pulse. Each pulse is one timer second.
//   Load       in   Load LoadValue. Only acts in IDLE or EXPIRED.
//   LoadValue  in   [6:0] Round length in seconds. Saturates at 99.
//   Start      in   Start, resume or restart the round.
//   Pause      in   Pause a running round.
//   Remaining  out  [6:0] Registered count of seconds left (0..99).
//   Tens       out  [3:0] BCD tens digit of Remaining.
//   Ones       out  [3:0] BCD ones digit of Remaining.
//   Running    out  Registered. High only in RUN.
//   Expired    out  Registered. High only in EXPIRED.
//   TimeUp     out  Registered. High for one cycle when EXPIRED is entered.
module round_timer #(
    parameter int unsigned DEFAULT_SECONDS = 60
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Ten,
    input  logic       Load,
    input  logic [6:0] LoadValue,
    input  logic       Start,
    input  logic       Pause,
    output logic [6:0] Remaining,
    output logic [3:0] Tens,
    output logic [3:0] Ones,
    output logic       Running,
    output logic       Expired,
    output logic       TimeUp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [6:0] MAX_SECONDS = 7'd99;
    localparam logic [6:0] INIT_VALUE  = 7'(DEFAULT_SECONDS);

    state_t     state, state_next;
    logic [6:0] reload, reload_next;
    logic [6:0] remaining_next;
    logic       time_up_next;
    logic [6:0] load_clamped;

    assign load_clamped = (LoadValue > MAX_SECONDS) ? MAX_SECONDS : LoadValue;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state     <= IDLE;
            Remaining <= INIT_VALUE;
            reload    <= INIT_VALUE;
            Running   <= 1'b0;
            Expired   <= 1'b0;
            TimeUp    <= 1'b0;
        end else begin
            state     <= state_next;
            Remaining <= remaining_next;
            reload    <= reload_next;
            // Flags come from the next state, so they change on the same
            // edge as the state register.
            Running   <= (state_next == RUN);
            Expired   <= (state_next == EXPIRED);
            TimeUp    <= time_up_next;
        end
    end

    // An event that does not apply in the current state does not block
    // lower-priority events. For example, Load during RUN lets Ten act.
    always_comb begin
        state_next     = state;
        remaining_next = Remaining;
        reload_next    = reload;
        time_up_next   = 1'b0;

        if (Load && (state == IDLE || state == EXPIRED)) begin
            remaining_next = load_clamped;
            reload_next    = load_clamped;
            state_next     = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Start && Remaining != '0) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (Pause) begin
                        state_next = PAUSED;
                    end else if (Ten) begin
                        // A count of 0 in RUN cannot happen. It is grouped
                        // with 1 so the count can never wrap.
                        if (Remaining > 7'd1) begin
                            remaining_next = Remaining - 7'd1;
                        end else begin
                            remaining_next = '0;
                            state_next     = EXPIRED;
                            time_up_next   = 1'b1;
                        end
                    end
                end
                PAUSED: begin
                    if (Start) begin
                        state_next = RUN;
                    end
                end
                EXPIRED: begin
                    if (Start && reload != '0) begin
                        remaining_next = reload;
                        state_next     = RUN;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Binary-to-BCD conversion for 0..99. The largest matching decade sets
    // the tens digit, and the rest of the count is the ones digit.
    always_comb begin
        Tens = '0;
        Ones = Remaining[3:0];
        for (int unsigned i = 1; i <= 9; i++) begin
            if (Remaining >= 7'(i * 10)) begin
                Tens = 4'(i);
                Ones = 4'(Remaining - 7'(i * 10));
            end
        end
    end

endmodule

// File: tb/tb_round_timer.sv
// tb_round_timer -- table-driven directed test for round_timer.
//
// Each vector drives one cycle of inputs. It then checks the registered
// outputs and the BCD digits just after the rising edge. A hand-written
// sequence covers reset with Ten high while running. A monitor checks
// that TimeUp is never high for two cycles in a row.
module tb_round_timer;

    logic       clock = 1'b0;
    logic       reset;
    logic       ten;
    logic       load;
    logic [6:0] load_value;
    logic       start;
    logic       pause;
    logic [6:0] remaining;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       running;
    logic       expired;
    logic       time_up;

    always #5 clock = ~clock;

    round_timer #(.DEFAULT_SECONDS(60)) dut (
        .Clock     (clock),
        .Reset     (reset),
        .Ten       (ten),
        .Load      (load),
        .LoadValue (load_value),
        .Start     (start),
        .Pause     (pause),
        .Remaining (remaining),
        .Tens      (tens),
        .Ones      (ones),
        .Running   (running),
        .Expired   (expired),
        .TimeUp    (time_up)
    );

    typedef struct {
        logic       rst_n;
        logic       ten;
        logic       load;
        logic [6:0] lv;
        logic       start;
        logic       pause;
        logic [6:0] rem;
        logic [3:0] tens;
        logic [3:0] ones;
        logic       run;
        logic       exp;
        logic       tu;
    } vec_t;

    vec_t vecs[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic chk(input string what, input logic [31:0] actual,
                       input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", what, actual, expected);
        end
    endtask

    task automatic add(input logic r, input logic t, input logic l,
                       input logic [6:0] lv, input logic s, input logic p,
                       input logic [6:0] rem, input logic [3:0] te,
                       input logic [3:0] on, input logic ru,
                       input logic ex, input logic tu);
        vec_t v;
        v.rst_n = r;   v.ten = t;    v.load = l;  v.lv = lv;
        v.start = s;   v.pause = p;  v.rem = rem; v.tens = te;
        v.ones = on;   v.run = ru;   v.exp = ex;  v.tu = tu;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic t, input logic l,
                         input logic [6:0] lv, input logic s, input logic p);
        reset = r; ten = t; load = l; load_value = lv; start = s; pause = p;
        @(posedge clock);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic [6:0] rem,
                                 input logic [3:0] te, input logic [3:0] on,
                                 input logic ru, input logic ex,
                                 input logic tu);
        chk({tag, " remaining"}, 32'(remaining), 32'(rem));
        chk({tag, " tens"},      32'(tens),      32'(te));
        chk({tag, " ones"},      32'(ones),      32'(on));
        chk({tag, " running"},   32'(running),   32'(ru));
        chk({tag, " expired"},   32'(expired),   32'(ex));
        chk({tag, " timeup"},    32'(time_up),   32'(tu));
    endtask

    // TimeUp must never be high on two samples in a row.
    logic prev_tu = 1'b0;
    always @(negedge clock) begin
        if (time_up === 1'b1) begin
            chk("timeup_consecutive", 32'(prev_tu), 32'd0);
        end
        prev_tu <= time_up;
    end

    initial begin
        reset = 1'b0; ten = 1'b0; load = 1'b0; load_value = '0;
        start = 1'b0; pause = 1'b0;

        //  rst ten ld  lv   st pa   rem tens ones run exp tu
        add(0, 0, 0, 7'd0,   0, 0,   7'd60, 4'd6, 4'd0, 0, 0, 0); // reset
        add(1, 0, 1, 7'd3,   0, 0,   7'd3,  4'd0, 4'd3, 0, 0, 0); // load 3
        add(1, 0, 0, 7'd0,   1, 0,   7'd3,  4'd0, 4'd3, 1, 0, 0); // start
        add(1, 1, 0, 7'd0,   0, 0,   7'd2,  4'd0, 4'd2, 1, 0, 0);
        add(1, 0, 0, 7'd0,   0, 0,   7'd2,  4'd0, 4'd2, 1, 0, 0); // no tick
        add(1, 1, 0, 7'd0,   0, 0,   7'd1,  4'd0, 4'd1, 1, 0, 0);
        add(1, 1, 0, 7'd0,   0, 0,   7'd0,  4'd0, 4'd0, 0, 1, 1); // expire
        add(1, 0, 0, 7'd0,   0, 0,   7'd0,  4'd0, 4'd0, 0, 1, 0);
        add(1, 1, 0, 7'd0,   0, 0,   7'd0,  4'd0, 4'd0, 0, 1, 0); // ten ignored
        add(1, 0, 0, 7'd0,   0, 1,   7'd0,  4'd0, 4'd0, 0, 1, 0); // pause ignored
        add(1, 0, 0, 7'd0,   1, 0,   7'd3,  4'd0, 4'd3, 1, 0, 0); // restart
        add(1, 0, 1, 7'd47,  0, 0,   7'd3,  4'd0, 4'd3, 1, 0, 0); // load in RUN
        add(1, 1, 0, 7'd0,   0, 0,   7'd2,  4'd0, 4'd2, 1, 0, 0);
        add(1, 1, 0, 7'd0,   0, 0,   7'd1,  4'd0, 4'd1, 1, 0, 0);
        add(1, 1, 0, 7'd0,   0, 0,   7'd0,  4'd0, 4'd0, 0, 1, 1);
        add(1, 0, 1, 7'd120, 0, 0,   7'd99, 4'd9, 4'd9, 0, 0, 0); // clamp
        add(1, 0, 1, 7'd100, 0, 0,   7'd99, 4'd9, 4'd9, 0, 0, 0);
        add(1, 0, 1, 7'd127, 0, 0,   7'd99, 4'd9, 4'd9, 0, 0, 0);
        add(1, 0, 1, 7'd99,  0, 0,   7'd99, 4'd9, 4'd9, 0, 0, 0);
        add(1, 0, 1, 7'd47,  0, 0,   7'd47, 4'd4, 4'd7, 0, 0, 0);
        add(1, 0, 1, 7'd2,   0, 0,   7'd2,  4'd0, 4'd2, 0, 0, 0);
        add(1, 0, 0, 7'd0,   1, 0,   7'd2,  4'd0, 4'd2, 1, 0, 0);
        add(1, 1, 0, 7'd0,   0, 0,   7'd1,  4'd0, 4'd1, 1, 0, 0);
        add(1, 1, 0, 7'd0,   0, 0,   7'd0,  4'd0, 4'd0, 0, 1, 1);
        add(1, 0, 0, 7'd0,   1, 0,   7'd2,  4'd0, 4'd2, 1, 0, 0); // restart 2
        add(1, 1, 0, 7'd0,   0, 0,   7'd1,  4'd0, 4'd1, 1, 0, 0);
        add(1, 1, 0, 7'd0,   0, 0,   7'd0,  4'd0, 4'd0, 0, 1, 1);
        add(1, 0, 1, 7'd5,   1, 0,   7'd5,  4'd0, 4'd5, 0, 0, 0); // load beats start
        add(1, 0, 0, 7'd0,   1, 0,   7'd5,  4'd0, 4'd5, 1, 0, 0);
        add(1, 1, 0, 7'd0,   0, 1,   7'd5,  4'd0, 4'd5, 0, 0, 0); // pause beats ten
        add(1, 1, 0, 7'd0,   0, 0,   7'd5,  4'd0, 4'd5, 0, 0, 0);
        add(1, 1, 0, 7'd0,   0, 0,   7'd5,  4'd0, 4'd5, 0, 0, 0);
        add(1, 1, 0, 7'd0,   0, 0,   7'd5,  4'd0, 4'd5, 0, 0, 0);
        add(1, 1, 0, 7'd0,   0, 0,   7'd5,  4'd0, 4'd5, 0, 0, 0);
        add(1, 0, 0, 7'd0,   0, 1,   7'd5,  4'd0, 4'd5, 0, 0, 0); // pause ignored
        add(1, 0, 0, 7'd0,   1, 0,   7'd5,  4'd0, 4'd5, 1, 0, 0); // resume
        add(1, 1, 0, 7'd0,   0, 0,   7'd4,  4'd0, 4'd4, 1, 0, 0);
        add(1, 1, 0, 7'd0,   0, 0,   7'd3,  4'd0, 4'd3, 1, 0, 0);
        add(1, 1, 0, 7'd0,   0, 0,   7'd2,  4'd0, 4'd2, 1, 0, 0);
        add(1, 1, 0, 7'd0,   0, 0,   7'd1,  4'd0, 4'd1, 1, 0, 0);
        add(1, 1, 0, 7'd0,   0, 0,   7'd0,  4'd0, 4'd0, 0, 1, 1);
        add(1, 0, 1, 7'd8,   1, 0,   7'd8,  4'd0, 4'd8, 0, 0, 0); // start discarded
        add(1, 0, 0, 7'd0,   1, 0,   7'd8,  4'd0, 4'd8, 1, 0, 0);
        add(0, 1, 1, 7'd5,   1, 0,   7'd60, 4'd6, 4'd0, 0, 0, 0); // reset wins
        add(1, 0, 1, 7'd0,   0, 0,   7'd0,  4'd0, 4'd0, 0, 0, 0); // load 0
        add(1, 0, 0, 7'd0,   1, 0,   7'd0,  4'd0, 4'd0, 0, 0, 0); // start ignored
        add(1, 0, 1, 7'd10,  0, 0,   7'd10, 4'd1, 4'd0, 0, 0, 0);
        add(1, 0, 0, 7'd0,   1, 0,   7'd10, 4'd1, 4'd0, 1, 0, 0); // RUN at 10

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].ten, vecs[i].load, vecs[i].lv,
                  vecs[i].start, vecs[i].pause);
            check_outputs($sformatf("v%0d", i), vecs[i].rem, vecs[i].tens,
                          vecs[i].ones, vecs[i].run, vecs[i].exp, vecs[i].tu);
        end

        // Reset for one edge with Ten high while RUN at 10. Later ticks
        // must leave the default count alone, because the timer is IDLE.
        drive(0, 1, 0, 7'd0, 0, 0);
        check_outputs("rst_mid_run", 7'd60, 4'd6, 4'd0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 0, 7'd0, 0, 0);
            check_outputs($sformatf("idle_tick%0d", k), 7'd60, 4'd6, 4'd0,
                          0, 0, 0);
            drive(1, 0, 0, 7'd0, 0, 0);
        end

        // A one-second round: expiry comes on the first tick, and TimeUp
        // drops on the next cycle.
        drive(1, 0, 1, 7'd1, 0, 0);
        drive(1, 0, 0, 7'd0, 1, 0);
        check_outputs("one_sec_run", 7'd1, 4'd0, 4'd1, 1, 0, 0);
        drive(1, 1, 0, 7'd0, 0, 0);
        check_outputs("one_sec_exp", 7'd0, 4'd0, 4'd0, 0, 1, 1);
        drive(1, 1, 0, 7'd0, 0, 0);
        check_outputs("one_sec_after", 7'd0, 4'd0, 4'd0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
